// File: rtl/text_banner_renderer.sv
// Scaled NUM_CHARS text overlay with typewriter reveal, driving a shared sync 8x16 font ROM.
// Optional blink once fully revealed: define TEXT_BANNER_BLINK_EN.
module text_banner_renderer #(
  parameter int unsigned NUM_CHARS     = 5,
  parameter int unsigned SCALE_LOG2    = 3,
  parameter int unsigned X0            = 160,
  parameter int unsigned Y0            = 128,
  parameter logic [NUM_CHARS*7-1:0] INIT_TEXT = {7'h68, 7'h73, 7'h61, 7'h72, 7'h43},
  parameter int unsigned REVEAL_FRAMES = 4,
  parameter int unsigned BLINK_FRAMES  = 30,
  localparam int unsigned PIX_W  = 10,
  localparam int unsigned IDX_W  = 4,
  localparam int unsigned CHAR_W = 7,
  localparam int unsigned ROW_W  = 4,
  localparam int unsigned ADDR_W = CHAR_W + ROW_W,
  localparam int unsigned FONT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable_i,
  input  logic              frame_tick_i,
  input  logic [PIX_W-1:0]  pix_x_i,
  input  logic [PIX_W-1:0]  pix_y_i,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [CHAR_W-1:0] wr_char_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [FONT_W-1:0] font_row_i,
  output logic              text_on_o,
  output logic              done_o
);

  localparam int unsigned CW    = 8 << SCALE_LOG2;
  localparam int unsigned CH    = 16 << SCALE_LOG2;
  localparam int unsigned X_END = X0 + NUM_CHARS * CW;
  localparam int unsigned Y_END = Y0 + CH;
  localparam int unsigned CNT_W = 5;
  localparam int unsigned DIV_W = (REVEAL_FRAMES > 1) ? $clog2(REVEAL_FRAMES) : 1;
  localparam int unsigned COL_W = 3;

  logic [CHAR_W-1:0] text_ram_q [NUM_CHARS];

  logic              enable_q;
  logic              rise;
  logic [CNT_W-1:0]  reveal_cnt_q, reveal_cnt_d;
  logic [DIV_W-1:0]  frame_div_q, frame_div_d;
  logic              done_q, done_d;
  logic              s1_in_box_q, s1_vis_q;
  logic [COL_W-1:0]  s1_col_q;
  logic              text_on_q, text_on_d;
  logic              blink_vis;

  logic              in_box;
  logic [PIX_W-1:0]  dx, dy;
  logic [IDX_W-1:0]  idx;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [CHAR_W-1:0] cur_char;
  logic              idx_vis;

  // Stage 0: box decode and glyph address; outside the box slot 0 is addressed.
  always_comb begin
    in_box   = (32'(pix_x_i) >= X0) && (32'(pix_x_i) < X_END) &&
               (32'(pix_y_i) >= Y0) && (32'(pix_y_i) < Y_END);
    dx       = pix_x_i - PIX_W'(X0);
    dy       = pix_y_i - PIX_W'(Y0);
    idx      = in_box ? IDX_W'(dx >> (SCALE_LOG2 + 3)) : '0;
    col      = COL_W'(dx >> SCALE_LOG2);
    row      = ROW_W'(dy >> SCALE_LOG2);
    cur_char = '0;
    for (int unsigned i = 0; i < NUM_CHARS; i++) begin
      if (idx == IDX_W'(i)) cur_char = text_ram_q[i];
    end
    idx_vis  = CNT_W'(idx) < reveal_cnt_q;
  end

  assign rom_addr_o = {cur_char, row};

  // Reveal sequencing; a restart takes priority over a coincident frame tick.
  always_comb begin
    rise         = enable_i && !enable_q;
    reveal_cnt_d = reveal_cnt_q;
    frame_div_d  = frame_div_q;
    if (!enable_i) begin
      reveal_cnt_d = '0;
      frame_div_d  = '0;
    end else if (rise) begin
      frame_div_d  = '0;
      reveal_cnt_d = (REVEAL_FRAMES == 0) ? CNT_W'(NUM_CHARS) : '0;
    end else if (frame_tick_i && (REVEAL_FRAMES != 0)) begin
      if (frame_div_q == DIV_W'(REVEAL_FRAMES - 1)) begin
        frame_div_d = '0;
        if (reveal_cnt_q != CNT_W'(NUM_CHARS)) reveal_cnt_d = reveal_cnt_q + CNT_W'(1);
      end else begin
        frame_div_d = frame_div_q + DIV_W'(1);
      end
    end
    done_d    = enable_i && (reveal_cnt_d == CNT_W'(NUM_CHARS));
    text_on_d = s1_in_box_q && s1_vis_q && enable_q && blink_vis &&
                font_row_i[3'd7 - s1_col_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_q     <= 1'b0;
      reveal_cnt_q <= '0;
      frame_div_q  <= '0;
      done_q       <= 1'b0;
      s1_in_box_q  <= 1'b0;
      s1_vis_q     <= 1'b0;
      s1_col_q     <= '0;
      text_on_q    <= 1'b0;
    end else begin
      enable_q     <= enable_i;
      reveal_cnt_q <= reveal_cnt_d;
      frame_div_q  <= frame_div_d;
      done_q       <= done_d;
      s1_in_box_q  <= in_box;
      s1_vis_q     <= idx_vis;
      s1_col_q     <= col;
      text_on_q    <= text_on_d;
    end
  end

  // Text RAM: slots beyond NUM_CHARS have no storage, so such writes fall away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_CHARS; i++) begin
        text_ram_q[i] <= INIT_TEXT[i*CHAR_W +: CHAR_W];
      end
    end else if (wr_en_i) begin
      for (int unsigned i = 0; i < NUM_CHARS; i++) begin
        if (wr_idx_i == IDX_W'(i)) text_ram_q[i] <= wr_char_i;
      end
    end
  end

`ifdef TEXT_BANNER_BLINK_EN
  localparam int unsigned BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_vis_q, blink_vis_d;

  // Blink phase runs only after full reveal and restarts visible with each banner.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_vis_d = blink_vis_q;
    if (!enable_i || rise) begin
      blink_cnt_d = '0;
      blink_vis_d = 1'b1;
    end else if (done_q && frame_tick_i) begin
      if (blink_cnt_q == BLINK_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_d = '0;
        blink_vis_d = !blink_vis_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      blink_vis_q <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_vis_q <= blink_vis_d;
    end
  end

  assign blink_vis = blink_vis_q;
`else
  logic unused_blink_cfg;
  assign unused_blink_cfg = ^BLINK_FRAMES;
  assign blink_vis        = 1'b1;
`endif

  assign text_on_o = text_on_q;
  assign done_o    = done_q;

endmodule
